// File: rtl/quant_unit.sv
// Two-stage requantizer: rounds each unsigned accumulator lane by a per-transfer
// right shift (round-half-up), clamps to 8 bits and counts saturated lanes.
module quant_unit #(
  parameter int LANES = 4,
  parameter int ACC_W = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*ACC_W-1:0] in_data,
  input  logic [4:0]             in_shift,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*8-1:0]     out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   sat_clr,
  output logic [15:0]            sat_count
);

  localparam int OUT_W = 8;
  localparam logic [ACC_W:0] ONE = {{ACC_W{1'b0}}, 1'b1};
  localparam logic [ACC_W:0] MAX_Q = {{(ACC_W-7){1'b0}}, 8'hFF};

  function automatic logic [15:0] satAdd(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic                 s1Valid_r;
  logic [ACC_W:0]       s1R_r [LANES];
  logic [4:0]           s1Shift_r;
  logic [4:0]           shiftClamp_s;
  logic [ACC_W:0]       roundAdd_s;
  logic [ACC_W:0]       s1Next_s [LANES];
  logic [ACC_W:0]       q_s [LANES];
  logic [LANES*OUT_W-1:0] s2Next_s;
  logic [15:0]          satLanes_s;
  logic                 s1Load_s;
  logic                 s2Load_s;

  assign s2Load_s = !out_valid || out_ready;
  assign s1Load_s = !s1Valid_r || s2Load_s;
  assign in_ready = s1Load_s;

  // S1 datapath: clamp the shift and add the half-LSB rounding term one bit wider than the input
  always_comb begin
    shiftClamp_s = (in_shift > 5'd16) ? 5'd16 : in_shift;
    roundAdd_s   = (shiftClamp_s == 5'd0) ? {(ACC_W+1){1'b0}} : (ONE << (shiftClamp_s - 5'd1));
    for (int i = 0; i < LANES; i++) begin
      s1Next_s[i] = {1'b0, in_data[i*ACC_W +: ACC_W]} + roundAdd_s;
    end
  end

  // S2 datapath: shift, clamp to 255 and count lanes that clamped
  always_comb begin
    satLanes_s = 16'd0;
    s2Next_s   = {(LANES*OUT_W){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      q_s[i] = s1R_r[i] >> s1Shift_r;
      if (q_s[i] > MAX_Q) begin
        s2Next_s[i*OUT_W +: OUT_W] = 8'hFF;
        satLanes_s = satLanes_s + 16'd1;
      end else begin
        s2Next_s[i*OUT_W +: OUT_W] = q_s[i][OUT_W-1:0];
      end
    end
  end

  // Pipeline registers, output register and saturation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_r <= 1'b0;
      s1Shift_r <= 5'd0;
      out_valid <= 1'b0;
      out_data  <= {(LANES*OUT_W){1'b0}};
      sat_count <= 16'd0;
      for (int i = 0; i < LANES; i++) begin
        s1R_r[i] <= {(ACC_W+1){1'b0}};
      end
    end else begin
      if (s1Load_s) begin
        s1Valid_r <= in_valid;
        if (in_valid) begin
          s1Shift_r <= shiftClamp_s;
          for (int i = 0; i < LANES; i++) begin
            s1R_r[i] <= s1Next_s[i];
          end
        end
      end
      // out_data only changes when a valid item moves in, so it holds under stall
      if (s2Load_s) begin
        out_valid <= s1Valid_r;
        if (s1Valid_r) begin
          out_data <= s2Next_s;
        end
      end
      if (sat_clr) begin
        sat_count <= 16'd0;
      end else if (s2Load_s && s1Valid_r) begin
        sat_count <= satAdd(sat_count, satLanes_s);
      end
    end
  end

endmodule

// File: tb/tb_quant_unit.sv
// Self-checking bench for quant_unit: directed corner cases plus randomized
// backpressure traffic scored against an arithmetic reference model.
module tb_quant_unit;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, sat_clr;
  logic [95:0] in_data;
  logic [4:0]  in_shift;
  logic [31:0] out_data;
  logic [15:0] sat_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  quant_unit #(.LANES(4), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_shift(in_shift), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic longint refQ(longint x, int sh);
    int s;
    longint r;
    s = (sh > 16) ? 16 : sh;
    r = x + ((s == 0) ? 64'd0 : (64'd1 << (s - 1)));
    return r >> s;
  endfunction

  function automatic logic [31:0] refOut(logic [95:0] d, logic [4:0] sh);
    logic [31:0] o;
    longint q;
    for (int i = 0; i < 4; i++) begin
      q = refQ(longint'(d[i*24 +: 24]), int'(sh));
      o[i*8 +: 8] = (q > 255) ? 8'hFF : 8'(q);
    end
    return o;
  endfunction

  function automatic int refSat(logic [95:0] d, logic [4:0] sh);
    int n = 0;
    for (int i = 0; i < 4; i++) if (refQ(longint'(d[i*24 +: 24]), int'(sh)) > 255) n++;
    return n;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one transfer with out_ready high; returns one cycle after S2 loads it.
  task automatic sendOne(logic [95:0] d, logic [4:0] sh);
    in_data = d; in_shift = sh; in_valid = 1'b1; out_ready = 1'b1;
    nextCycle();
    in_valid = 1'b0;
    nextCycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0; in_data = 96'd0; in_shift = 5'd0;
    repeat (3) nextCycle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_sat got %h exp 0", sat_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    in_data = {24'd0, 24'd0, 24'h000100, 24'h0000C8}; in_shift = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b exp 1", in_ready); end
    nextCycle();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
    nextCycle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'h0000FFC8) begin errors++; $display("FAIL basic_data got %h exp 0000ffc8", out_data); end
    checks++; if (sat_count !== 16'd1) begin errors++; $display("FAIL basic_sat got %h exp 1", sat_count); end
    nextCycle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_dup got %b exp 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_round();
    sendOne({24'd0, 24'h000008, 24'h000017, 24'h000018}, 5'd4);
    @(negedge clk);
    checks++; if (out_data !== 32'h00010102) begin errors++; $display("FAIL round_data got %h exp 00010102", out_data); end
    checks++; if (sat_count !== 16'd1) begin errors++; $display("FAIL round_sat got %h exp 1", sat_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_big();
    sendOne({24'd0, 24'd0, 24'd0, 24'hFFFFFF}, 5'd8);
    @(negedge clk);
    checks++; if (out_data !== 32'h000000FF) begin errors++; $display("FAIL big_data got %h exp 000000ff", out_data); end
    checks++; if (sat_count !== 16'd2) begin errors++; $display("FAIL big_sat got %h exp 2", sat_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_clamp();
    // shift 31 behaves as 16
    sendOne({24'h007FFF, 24'h017FFF, 24'h018000, 24'hFFFFFF}, 5'd31);
    @(negedge clk);
    checks++; if (out_data !== 32'h000102FF) begin errors++; $display("FAIL clamp_data got %h exp 000102ff", out_data); end
    checks++; if (sat_count !== 16'd3) begin errors++; $display("FAIL clamp_sat got %h exp 3", sat_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [95:0] d [3];
    logic [4:0]  sh [3];
    logic [31:0] exp [$];
    int got = 0;
    bit pending;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) d[k][i*24 +: 24] = 24'($urandom);
      sh[k] = 5'($urandom_range(0, 20));
      exp.push_back(refOut(d[k], sh[k]));
    end
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data = d[k]; in_shift = sh[k];
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept%0d got %b exp 1", k, in_ready); end
      nextCycle();
    end
    in_data = d[2]; in_shift = sh[2];
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== exp[0]) begin errors++; $display("FAIL bp_hold got %b/%h exp 1/%h", out_valid, out_data, exp[0]); end
    nextCycle();
    @(negedge clk);
    checks++; if (out_data !== exp[0]) begin errors++; $display("FAIL bp_stable got %h exp %h", out_data, exp[0]); end
    @(posedge clk); #1;
    out_ready = 1'b1; pending = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (pending && in_ready) pending = 1'b0;
      if (out_valid) begin
        checks++;
        if (got >= 3) begin errors++; $display("FAIL bp_extra got %h exp none", out_data); end
        else if (out_data !== exp[got]) begin errors++; $display("FAIL bp_order%0d got %h exp %h", got, out_data, exp[got]); end
        got++;
      end
      @(posedge clk); #1;
      if (!pending) in_valid = 1'b0;
    end
    checks++; if (got != 3) begin errors++; $display("FAIL bp_count got %0d exp 3", got); end
  endtask

  task automatic test_reset_mid();
    in_data = {4{24'hFFFFFF}}; in_shift = 5'd0; out_ready = 1'b0; in_valid = 1'b1;
    nextCycle();
    nextCycle();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rm_full got %b/%b exp 0/1", in_ready, out_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    nextCycle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b exp 0", out_valid); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL rm_sat got %h exp 0", sat_count); end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b exp 1", in_ready); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale got %b exp 0", out_valid); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_counter();
    int acc = 0;
    in_data = {4{24'hFFFFFF}}; in_shift = 5'd0; out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 16384; c++) begin
      if (c == 16383) in_data = {24'd0, 24'd0, 24'hFFFFFF, 24'hFFFFFF};
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) nextCycle();
    @(negedge clk);
    checks++; if (acc != 16384) begin errors++; $display("FAIL cnt_throughput got %0d exp 16384", acc); end
    checks++; if (sat_count !== 16'hFFFE) begin errors++; $display("FAIL cnt_preload got %h exp fffe", sat_count); end
    @(posedge clk); #1;
    sendOne({4{24'hFFFFFF}}, 5'd0);
    nextCycle();
    @(negedge clk);
    checks++; if (sat_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate got %h exp ffff", sat_count); end
    @(posedge clk); #1;
    in_data = {4{24'hFFFFFF}}; in_valid = 1'b1;
    nextCycle();
    in_valid = 1'b0; sat_clr = 1'b1;
    nextCycle();
    sat_clr = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cnt_clr_event got %b exp 1", out_valid); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL cnt_clr got %h exp 0", sat_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] exp [$];
    logic [31:0] prevData = 32'd0;
    bit holdPrev = 1'b0;
    int expSat = 0;
    rst = 1'b1; in_valid = 1'b0;
    nextCycle();
    rst = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 2))
          0: in_data[i*24 +: 24] = 24'($urandom_range(0, 600));
          1: in_data[i*24 +: 24] = 24'($urandom);
          default: in_data[i*24 +: 24] = 24'hFFFFFF;
        endcase
      end
      in_shift  = 5'($urandom_range(0, 31));
      in_valid  = (c < 900) && ($urandom_range(0, 3) != 0);
      out_ready = (c >= 900) || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (holdPrev) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prevData) begin errors++; $display("FAIL rnd_stable got %b/%h exp 1/%h", out_valid, out_data, prevData); end
      end
      if (in_valid && in_ready) begin
        exp.push_back(refOut(in_data, in_shift));
        expSat += refSat(in_data, in_shift);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp.size() == 0) begin errors++; $display("FAIL rnd_spurious got %h exp none", out_data); end
        else begin
          if (out_data !== exp[0]) begin errors++; $display("FAIL rnd_data got %h exp %h", out_data, exp[0]); end
          void'(exp.pop_front());
        end
      end
      holdPrev = out_valid && !out_ready;
      prevData = out_data;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (exp.size() != 0) begin errors++; $display("FAIL rnd_lost got %0d exp 0", exp.size()); end
    checks++; if (sat_count !== 16'((expSat > 65535) ? 65535 : expSat)) begin errors++; $display("FAIL rnd_sat got %0d exp %0d", sat_count, expSat); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_big();
    test_clamp();
    test_backpressure();
    test_reset_mid();
    test_counter();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
